regfile_wr_sched: RTL
=====================

Name: regfile_wr_sched

Overview:
- Scheduler for the register file's single write port (regWr/WriteAddr/WriteData).
- Shares the port between NREQ writeback requesters (ALU, load path, I/O) using round-robin arbitration and a valid/ready handshake.
- Also owns a clear-sweep FSM that zeroes every register on command, so bulk initialisation never depends on register-file reset behaviour.
- Sits between the writeback sources and the register file; its outputs drive the file's write port directly.

Parameters:
- NREQ, 3, number of write requesters (2..8).
- ADDR_W, 5, register address width.
- DATA_W, 8, write data width.
- NREGS, 32, registers swept by a clear (1..2^ADDR_W).

Ports:
- CLK  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-low.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*ADDR_W  packed target addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_data  in  NREQ*DATA_W  packed write data; requester i uses slice [i*DATA_W +: DATA_W].
- req_ready  out  NREQ  one-hot accept, combinational.
- clr_start  in  1  request a clear sweep.
- clr_busy  out  1  sweep in progress.
- clr_done  out  1  one-cycle pulse on the last sweep write.
- regWr  out  1  register file write enable, registered.
- WriteAddr  out  ADDR_W  register file write address, registered.
- WriteData  out  DATA_W  register file write data, registered.

Behaviour:
- reset==0 at an edge (also mid-sweep or mid-transfer):
  - state=IDLE, rr pointer=0 (requester 0 highest priority).
  - regWr=0, WriteAddr=0, WriteData=0, clr_busy=0, clr_done=0.
  - req_ready=0 while reset is low; a sweep in progress is abandoned, not resumed.
- States: IDLE (arbitrating), CLEAR (sweeping).
- IDLE, arbitration:
  - Grant goes to the first valid requester found scanning from rr pointer upward with wrap.
  - req_ready[grant]=1 only if state==IDLE, clr_start==0 and reset==1. At most one ready bit is set.
  - req_ready may depend combinationally on req_valid; requesters must not make req_valid depend on req_ready.
- Accept and write timing:
  - Accept = valid & ready in cycle t.
  - At t+1: regWr=1, WriteAddr/WriteData = that requester's slices.
  - rr pointer <= (granted index + 1) mod NREQ.
  - Back-to-back accepts every cycle are allowed. With no accept, regWr=0 next cycle; addr/data hold their last value.
- Precedence: clr_start in IDLE beats all requests. No accept that cycle; state -> CLEAR.
- CLEAR:
  - For clr_start at cycle t, the cycles t+1..t+NREGS carry regWr=1, WriteData=0, WriteAddr = 0,1,...,NREGS-1 (one per cycle).
  - clr_busy=1 for exactly those cycles; clr_done=1 only at t+NREGS.
  - req_ready=0 throughout. Pending requests wait, keep their valid asserted, and are not dropped.
  - clr_start during CLEAR is ignored: no restart, no queuing.
  - After the sweep, state=IDLE at t+NREGS+1; a request can be accepted in that cycle and written at t+NREGS+2.
  - rr pointer is unchanged by a sweep.
- Width rules:
  - Sweep counter is ADDR_W+1 bits, so NREGS=2^ADDR_W terminates without wrap ambiguity.
  - Addresses from requesters pass through unmodified. Writes to any address, including 0, are legal.
- No write reordering: port order equals accept order.

Decomposition:
- Shared package regfile_pkg holds the state enum (IDLE, CLEAR) and the width constants ADDR_W/DATA_W, shared with the register file and datapath.
- Sub-module rr_arbiter (NREQ param): inputs valid and ptr, output one-hot grant and granted index. Purely combinational; the pointer register stays in regfile_wr_sched.

Test Plan:
- Reset, then req_valid=3'b001, addr0=5'd3, data0=8'hA5 at t -> req_ready=3'b001 at t; at t+1 regWr=1, WriteAddr=3, WriteData=A5; at t+2 regWr=0.
- All three valid continuously for 6 cycles -> grants 0,1,2,0,1,2; one write per cycle; WriteAddr follows each requester's address.
- clr_start at t with req_valid=3'b010 held -> req_ready=0 at t..t+32; writes addr 0..31 with data 0 at t+1..t+32; clr_done only at t+32; requester 1 accepted at t+33 and written at t+34.
- clr_start pulsed again at t+10 during a sweep -> ignored; sweep still ends with clr_done at t+32; no second sweep.
- reset low at t+5 of a sweep -> at t+6 regWr=0, clr_busy=0, state IDLE; after release a fresh clr_start restarts from addr 0.
- Last grant to requester 2, then only req_valid=3'b101 -> requester 0 is granted first (wrap), then requester 2.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: port widths and the write-scheduler state encoding.
package regfile_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } wr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or above ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  logic [2*NREQ-1:0] valid_dbl;
  logic [2*NREQ-1:0] valid_rot;
  logic [IdxW:0]     sum;

  assign valid_dbl = {valid_i, valid_i};
  assign valid_rot = valid_dbl >> ptr_i;

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    sum   = '0;
    // Bit off of the rotated vector is requester (ptr + off) mod NREQ.
    for (int off = 0; off < NREQ; off++) begin
      if (!any_o && valid_rot[off]) begin
        any_o = 1'b1;
        sum   = {1'b0, ptr_i} + (IdxW + 1)'(off);
        if (sum >= (IdxW + 1)'(NREQ)) begin
          sum = sum - (IdxW + 1)'(NREQ);
        end
        idx_o = sum[IdxW-1:0];
      end
    end
  end

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_o[i] = any_o && (idx_o == IdxW'(i));
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Register-file write-port scheduler: round-robin writeback arbitration plus a
// clear sweep that writes zero to every register on command.
module regfile_wr_sched #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned NREGS  = 32
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     clr_start,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     regWr,
  output logic [ADDR_W-1:0]        WriteAddr,
  output logic [DATA_W-1:0]        WriteData
);

  import regfile_pkg::*;

  localparam int unsigned IdxW = $clog2(NREQ);
  // One extra bit so NREGS == 2**ADDR_W still has a distinct terminal count.
  localparam logic [ADDR_W:0] LastCnt = (ADDR_W + 1)'(NREGS - 1);

  wr_state_e         state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   rr_q, rr_d;
  logic              regwr_q, regwr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [NREQ-1:0]   gnt;
  logic [IdxW-1:0]   gnt_idx;
  logic              gnt_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_arb (
    .valid_i (req_valid),
    .ptr_i   (rr_q),
    .grant_o (gnt),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    regwr_d   = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    req_ready = '0;
    unique case (state_q)
      StIdle: begin
        if (clr_start) begin
          state_d = StClear;
          cnt_d   = '0;
          regwr_d = 1'b1;
          waddr_d = '0;
          wdata_d = '0;
          busy_d  = 1'b1;
          done_d  = (LastCnt == '0);
        end else if (gnt_any && reset) begin
          req_ready = gnt;
          regwr_d   = 1'b1;
          waddr_d   = req_addr[gnt_idx*ADDR_W +: ADDR_W];
          wdata_d   = req_data[gnt_idx*DATA_W +: DATA_W];
          rr_d      = (gnt_idx == IdxW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      StClear: begin
        // cnt_q is the address currently on the port; stage the next one.
        if (cnt_q == LastCnt) begin
          state_d = StIdle;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          regwr_d = 1'b1;
          waddr_d = cnt_d[ADDR_W-1:0];
          wdata_d = '0;
          busy_d  = 1'b1;
          done_d  = (cnt_d == LastCnt);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rr_q    <= '0;
      regwr_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      regwr_q <= regwr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign regWr     = regwr_q;
  assign WriteAddr = waddr_q;
  assign WriteData = wdata_q;
  assign clr_busy  = busy_q;
  assign clr_done  = done_q;

endmodule
